dvp_tx: RTL
===========

Name: dvp_tx

Overview:
- DVP (OV5640-style) video transmitter/sensor emulator: takes RGB565 pixels over a valid/ready stream and drives an 8-bit parallel camera bus (vsync, href, data).
- Emits the high byte first, then the low byte, per pixel, with programmable line and frame blanking.
- Used as a loop-back source for the camera receive path in simulation and on-board self-test, and as a sensor stand-in when no camera is fitted.

Parameters:
- H_ACTIVE, 640, active pixels per line (each pixel = 2 byte cycles).
- H_BLANK, 288, byte cycles with href low at end of every line (>=2).
- V_ACTIVE, 480, active lines per frame.
- VS_LINES, 4, lines with vsync high at frame start.
- V_BACK, 16, blank lines after vsync, before first active line.
- V_FRONT, 8, blank lines after last active line.

Ports:
- pclk_i  input  1  pixel/byte clock; all logic on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- en_i  input  1  run enable; sampled only at frame boundaries.
- pix_valid_i  input  1  source has a pixel.
- pix_data_i  input  16  RGB565 pixel {R[4:0],G[5:0],B[4:0]}.
- pix_ready_o  output  1  pixel accepted this cycle when high with pix_valid_i.
- cmos_vsync_o  output  1  frame sync, active high.
- cmos_href_o  output  1  line valid, active high.
- cmos_data_o  output  8  byte bus.
- frame_done_o  output  1  one-cycle pulse after last V_FRONT line ends.
- underrun_o  output  1  sticky: a pixel was needed but pix_valid_i was low.

Behaviour:
- Reset: every output 0; FSM to IDLE; counters 0. Reset mid-frame aborts immediately; next frame starts from VSYNC.
- Line timing: LINE_LEN = 2*H_ACTIVE + H_BLANK cycles; h counter 0..LINE_LEN-1 wraps, incrementing v counter on wrap.
- FSM: IDLE -> VSYNC when en_i=1 (checked in IDLE only); VSYNC (VS_LINES lines) -> VBACK (V_BACK lines) -> ACTIVE (V_ACTIVE lines) -> VFRONT (V_FRONT lines) -> VSYNC if en_i=1, else IDLE. A zero-length V_BACK or V_FRONT skips that state.
- Deasserting en_i mid-frame completes the current frame; no truncation.
- All bus outputs are registered; they lag the counters by exactly 1 cycle.
- cmos_vsync_o = 1 for all cycles of VSYNC lines; cmos_href_o is 0 there.
- In ACTIVE: cmos_href_o = 1 for h in [0, 2*H_ACTIVE-1], else 0. href is never high outside ACTIVE.
- Pixel fetch: pix_ready_o = 1 (combinational from counters) in ACTIVE when h < 2*H_ACTIVE and h is even. Elsewhere it is 0.
- Capture: when pix_ready_o is high, pix_data_i is latched if pix_valid_i=1.
  - Next cycle: cmos_data_o = pix[15:8].
  - Cycle after: cmos_data_o = pix[7:0].
- Underrun: pix_ready_o=1 and pix_valid_i=0 -> that pixel is sent as 0x00, 0x00, timing is unchanged, and underrun_o is set. underrun_o clears only on rst_i.
- cmos_data_o = 0x00 whenever href is low.
- frame_done_o pulses for 1 cycle, coincident with the first cycle after the final VFRONT line (or after the last ACTIVE line if V_FRONT=0).
- No back-pressure from the bus: pixel timing is fixed, and the source must keep up.

Test Plan:
Bench parameters for all tests: H_ACTIVE=4, H_BLANK=4, V_ACTIVE=2, VS_LINES=1, V_BACK=1, V_FRONT=1, giving LINE_LEN=12 and a 60-cycle frame.
- Basic frame: rst_i pulse, en_i=1, source always valid with pixels 0x1234, 0x5678, 0x9ABC, 0xDEF0 -> vsync high 12 cycles, then 12 idle cycles. Each active line then has href high 8 cycles with data 12,34,56,78,9A,BC,DE,F0 followed by 4 cycles of href low and data 00. frame_done pulses once 60 cycles after vsync rise. underrun_o stays 0.
- Handshake: count pix_ready_o&&pix_valid_i per frame -> exactly 8 transfers. pix_ready_o is high only on even h inside active lines.
- Underrun: pix_valid_i low for the 2nd pixel of line 1 -> bytes 3-4 are 00,00, href timing is unchanged, underrun_o goes 1 and stays 1 until rst_i.
- Enable drop: en_i=0 during ACTIVE line 0 -> frame completes with frame_done, FSM returns to IDLE, and vsync stays 0. Re-asserting en_i starts a new vsync on the next cycle's evaluation.
- Reset mid-line: rst_i during href high -> next cycle all outputs are 0. Release rst_i with en_i=1 -> vsync restarts with a full VS_LINES period.
- Receiver loopback: connect to the camera receive block for 7 frames -> from the 6th frame on, its 16-bit output equals the transmitted pixels.

Source files
------------

// File: rtl/dvp_tx_if.sv
// Pixel stream (valid/ready RGB565) and DVP camera bus bundled for dvp_tx.
// master is the pixel source / bus observer; slave is the transmitter.
interface dvp_tx_if;
   logic        pix_valid;
   logic [15:0] pix_data;
   logic        pix_ready;
   logic        cmos_vsync;
   logic        cmos_href;
   logic [7:0]  cmos_data;

   modport master (
      output pix_valid, pix_data,
      input  pix_ready, cmos_vsync, cmos_href, cmos_data
   );

   modport slave (
      input  pix_valid, pix_data,
      output pix_ready, cmos_vsync, cmos_href, cmos_data
   );
endinterface

// File: rtl/dvp_tx.sv
// DVP (OV5640-style) transmitter: RGB565 stream in, 8-bit vsync/href/data bus out,
// high byte first, with programmable line and frame blanking.
module dvp_tx #(
   parameter int H_ACTIVE = 640,
   parameter int H_BLANK  = 288,
   parameter int V_ACTIVE = 480,
   parameter int VS_LINES = 4,
   parameter int V_BACK   = 16,
   parameter int V_FRONT  = 8
) (
   input  logic     pclk_i,
   input  logic     rst_i,
   input  logic     en_i,
   dvp_tx_if.slave  bus,
   output logic     frame_done_o,
   output logic     underrun_o
);

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int LINE_LEN = 2*H_ACTIVE + H_BLANK;
   localparam int HW       = $clog2(LINE_LEN);
   localparam int MAXL     = max2(max2(VS_LINES, V_BACK), max2(V_ACTIVE, V_FRONT));
   localparam int VW       = $clog2(MAXL + 1);

   localparam logic [HW-1:0] H_LAST    = HW'(LINE_LEN - 1);
   localparam logic [HW-1:0] H_ACT_END = HW'(2*H_ACTIVE);
   localparam logic [VW-1:0] VS_LAST   = VW'(VS_LINES - 1);
   localparam logic [VW-1:0] VB_LAST   = VW'(V_BACK - 1);
   localparam logic [VW-1:0] VA_LAST   = VW'(V_ACTIVE - 1);
   localparam logic [VW-1:0] VF_LAST   = VW'(V_FRONT - 1);
   localparam bit            HAS_BACK  = (V_BACK > 0);
   localparam bit            HAS_FRONT = (V_FRONT > 0);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_VSYNC  = 3'd1;
   localparam logic [2:0] S_VBACK  = 3'd2;
   localparam logic [2:0] S_ACTIVE = 3'd3;
   localparam logic [2:0] S_VFRONT = 3'd4;

   logic [2:0]    state;
   logic [2:0]    next_state;
   logic [HW-1:0] h;
   logic [VW-1:0] v;
   logic          line_last;
   logic          active_byte;
   logic          frame_end;
   logic          frame_end_q;
   logic [7:0]    lo_byte;

   always_comb begin
      line_last  = 1'b0;
      next_state = S_IDLE;
      case (state)
         S_VSYNC: begin
            line_last  = (v == VS_LAST);
            next_state = HAS_BACK ? S_VBACK : S_ACTIVE;
         end
         S_VBACK: begin
            line_last  = (v == VB_LAST);
            next_state = S_ACTIVE;
         end
         S_ACTIVE: begin
            line_last  = (v == VA_LAST);
            next_state = HAS_FRONT ? S_VFRONT : (en_i ? S_VSYNC : S_IDLE);
         end
         S_VFRONT: begin
            line_last  = (v == VF_LAST);
            next_state = en_i ? S_VSYNC : S_IDLE;
         end
         default: begin
            line_last  = 1'b0;
            next_state = S_IDLE;
         end
      endcase
   end

   // Counter-domain view of the current byte slot; the bus registers lag it by one cycle.
   always_comb begin
      active_byte   = (state == S_ACTIVE) && (h < H_ACT_END);
      frame_end     = (h == H_LAST) && line_last &&
                      ((state == S_VFRONT) || ((state == S_ACTIVE) && !HAS_FRONT));
      bus.pix_ready = !rst_i && active_byte && !h[0];
   end

   always_ff @(posedge pclk_i) begin
      if (rst_i) begin
         state          <= S_IDLE;
         h              <= '0;
         v              <= '0;
         lo_byte        <= '0;
         frame_end_q    <= 1'b0;
         frame_done_o   <= 1'b0;
         underrun_o     <= 1'b0;
         bus.cmos_vsync <= 1'b0;
         bus.cmos_href  <= 1'b0;
         bus.cmos_data  <= '0;
      end else begin
         bus.cmos_vsync <= (state == S_VSYNC);
         bus.cmos_href  <= active_byte;
         // Pulse lands on the first bus cycle after the last line, hence two stages.
         frame_end_q    <= frame_end;
         frame_done_o   <= frame_end_q;

         if (active_byte) begin
            if (!h[0]) begin
               bus.cmos_data <= bus.pix_valid ? bus.pix_data[15:8] : 8'h00;
               lo_byte       <= bus.pix_valid ? bus.pix_data[7:0]  : 8'h00;
            end else begin
               bus.cmos_data <= lo_byte;
            end
         end else begin
            bus.cmos_data <= '0;
         end

         if (bus.pix_ready && !bus.pix_valid) begin
            underrun_o <= 1'b1;
         end

         if (state == S_IDLE) begin
            h <= '0;
            v <= '0;
            if (en_i) begin
               state <= S_VSYNC;
            end
         end else if (h == H_LAST) begin
            h <= '0;
            if (line_last) begin
               v     <= '0;
               state <= next_state;
            end else begin
               v <= v + 1'b1;
            end
         end else begin
            h <= h + 1'b1;
         end
      end
   end

endmodule
